// File: rtl/pc_sequencer_pkg.sv
// Shared op encodings, FSM state type and sizing helper for the PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Stack logic is built only when PC_CALL_STACK_EN is defined.
package pc_seq_pkg;

   // Sequencing operations presented by the decoder on i_op
   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_INC  = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } seq_state_e;

   // Width needed to count 0..depth valid stack entries
   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer bundle: op/target/enable/resume in, fetch address and status out.
// Latency: none (wires only).
// Backpressure: i_en stalls the sequencer; no ready signal is returned.
interface pc_sequencer_if #(
   parameter int PC_W        = 11,
   parameter int STACK_DEPTH = 4
) ();
   import pc_seq_pkg::*;

   localparam int LVL_W = lvl_w(STACK_DEPTH);

   logic             i_en;
   logic [2:0]       i_op;
   logic [PC_W-1:0]  i_target;
   logic             i_resume;
   logic [PC_W-1:0]  o_pc;
   logic             o_halted;
   logic             o_fault;
   logic [LVL_W-1:0] o_stack_level;

   // Decoder side
   modport master (
      output i_en, i_op, i_target, i_resume,
      input  o_pc, o_halted, o_fault, o_stack_level
   );

   // Sequencer side
   modport slave (
      input  i_en, i_op, i_target, i_resume,
      output o_pc, o_halted, o_fault, o_stack_level
   );

endinterface

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; top entry is read combinationally from the register array.
// Latency: push/pop take effect on the next rising edge; top/level/full/empty reflect state.
// Backpressure: push when full and pop when empty are ignored; the caller decides to fault.
module pc_return_stack
   import pc_seq_pkg::*;
#(
   parameter int PC_W        = 11,
   parameter int STACK_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic [PC_W-1:0]             data_i,
   output logic [PC_W-1:0]             top_o,
   output logic [lvl_w(STACK_DEPTH)-1:0] level_o,
   output logic                        full_o,
   output logic                        empty_o
);

   localparam int LVL_W = lvl_w(STACK_DEPTH);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0]  mem_q [STACK_DEPTH];
   logic [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0] level_m1;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             do_push, do_pop;

   assign full_o   = (level_q == LVL_W'(STACK_DEPTH));
   assign empty_o  = (level_q == '0);
   assign do_push  = push_i && !full_o;
   assign do_pop   = pop_i && !empty_o;
   assign level_m1 = level_q - LVL_W'(1);
   assign wr_idx   = IDX_W'(level_q);
   assign rd_idx   = IDX_W'(level_m1);
   assign top_o    = mem_q[rd_idx];
   assign level_o  = level_q;

   // Next occupancy: push and pop are mutually exclusive by construction
   always_comb begin
      level_d = level_q;
      if (do_push) begin
         level_d = level_q + LVL_W'(1);
      end else if (do_pop) begin
         level_d = level_m1;
      end
   end

   // Occupancy counter; entries themselves need no reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   // Write the pushed return address into the next free slot
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: hold/inc/jump/branch/call/return with halt and fault states.
// Latency: one cycle, op sampled at an edge is visible on o_pc right after it.
// Backpressure: i_en low freezes PC, stack and state; i_resume is honoured regardless of i_en.
// Build option: define PC_CALL_STACK_EN for the return stack; otherwise CALL=JMP, RET=NOP.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W        = 11,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   pc_sequencer_if.slave bus
);

   localparam int LVL_W = lvl_w(STACK_DEPTH);

   seq_state_e      state_q;
   logic [PC_W-1:0] pc_q;
   logic            halted_q;
   logic [PC_W-1:0] pc_plus1;
   logic            run_go;

   assign pc_plus1 = pc_q + PC_W'(1);
   assign run_go   = (state_q == ST_RUN) && bus.i_en;

   assign bus.o_pc     = pc_q;
   assign bus.o_halted = halted_q;

`ifdef PC_CALL_STACK_EN
   logic             fault_q;
   logic             stk_push, stk_pop;
   logic [PC_W-1:0]  stk_top;
   logic [LVL_W-1:0] stk_level;
   logic             stk_full, stk_empty;

   // Stack requests come straight from the decoded op so the top is consumed in the same edge
   assign stk_push = run_go && (bus.i_op == OP_CALL);
   assign stk_pop  = run_go && (bus.i_op == OP_RET);

   pc_return_stack #(
      .PC_W        (PC_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .data_i  (pc_plus1),
      .top_o   (stk_top),
      .level_o (stk_level),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   assign bus.o_fault       = fault_q;
   assign bus.o_stack_level = stk_level;
`else
   assign bus.o_fault       = 1'b0;
   assign bus.o_stack_level = '0;
`endif

   // Sequencing FSM with registered PC and status outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
`ifdef PC_CALL_STACK_EN
         fault_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_RUN: begin
               if (run_go) begin
                  case (bus.i_op)
                     OP_INC:  pc_q <= pc_plus1;
                     OP_JMP:  pc_q <= bus.i_target;
                     // Offset is PC_W wide, so a plain modulo add is the sign-extended add
                     OP_BR:   pc_q <= pc_q + bus.i_target;
`ifdef PC_CALL_STACK_EN
                     OP_CALL: begin
                        if (stk_full) begin
                           state_q <= ST_FAULT;
                           fault_q <= 1'b1;
                        end else begin
                           pc_q <= bus.i_target;
                        end
                     end
                     OP_RET: begin
                        if (stk_empty) begin
                           state_q <= ST_FAULT;
                           fault_q <= 1'b1;
                        end else begin
                           pc_q <= stk_top;
                        end
                     end
`else
                     OP_CALL: pc_q <= bus.i_target;
`endif
                     OP_HALT: begin
                        pc_q     <= pc_plus1;
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_HALTED: begin
               // The op on the resume edge is dropped; decoding restarts next edge
               if (bus.i_resume) begin
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
               end
            end
            ST_FAULT: ;
            default: state_q <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with immediate-assertion checks.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: exercises i_en stalls, halt/resume and (with PC_CALL_STACK_EN) stack faults.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   localparam int PC_W        = 11;
   localparam int STACK_DEPTH = 4;

   logic i_clk = 1'b0;
   logic i_rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   pc_sequencer_if #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

   pc_sequencer #(
      .PC_W        (PC_W),
      .STACK_DEPTH (STACK_DEPTH),
      .RESET_PC    (11'd0)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present one op for one edge, then sample
   task automatic step(input logic [2:0] op, input logic [PC_W-1:0] tgt,
                       input logic en = 1'b1, input logic res = 1'b0);
      bus.i_op     = op;
      bus.i_target = tgt;
      bus.i_en     = en;
      bus.i_resume = res;
      tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      step(OP_INC, 11'd5, 1'b1, 1'b1);
      step(OP_JMP, 11'd9, 1'b1, 1'b1);
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst        = 1'b1;
      bus.i_en     = 1'b0;
      bus.i_op     = OP_NOP;
      bus.i_target = '0;
      bus.i_resume = 1'b0;

      // Reset with busy inputs: reset wins
      do_reset();
      chk("rst_pc", 32'(bus.o_pc), 32'd0);
      chk("rst_halted", 32'(bus.o_halted), 32'd0);
      chk("rst_fault", 32'(bus.o_fault), 32'd0);
      chk("rst_level", 32'(bus.o_stack_level), 32'd0);

      // Increment sequencing
      step(OP_INC, '0);
      chk("inc1", 32'(bus.o_pc), 32'd1);
      step(OP_INC, '0);
      step(OP_INC, '0);
      chk("inc3", 32'(bus.o_pc), 32'd3);
      step(OP_NOP, 11'd77);
      chk("nop_hold", 32'(bus.o_pc), 32'd3);
      step(3'd7, 11'd77);
      chk("rsvd_hold", 32'(bus.o_pc), 32'd3);

      // Wrap at top of address space
      step(OP_JMP, 11'd2047);
      chk("jmp_top", 32'(bus.o_pc), 32'd2047);
      step(OP_INC, '0);
      chk("inc_wrap", 32'(bus.o_pc), 32'd0);

      // Branches: backward, forward, and backward across zero
      step(OP_JMP, 11'd10);
      step(OP_BR, 11'h7FD);
      chk("br_neg3", 32'(bus.o_pc), 32'd7);
      step(OP_BR, 11'd5);
      chk("br_pos5", 32'(bus.o_pc), 32'd12);
      step(OP_BR, 11'h7F0);
      chk("br_wrap", 32'(bus.o_pc), 32'd2044);
      step(OP_JMP, 11'd12);

      // Stall: INC with i_en low for 4 edges
      for (int i = 0; i < 4; i++) step(OP_INC, '0, 1'b0);
      chk("stall_pc", 32'(bus.o_pc), 32'd12);
      // i_resume in RUN has no effect
      step(OP_INC, '0, 1'b1, 1'b1);
      chk("resume_in_run", 32'(bus.o_pc), 32'd13);
      chk("resume_in_run_h", 32'(bus.o_halted), 32'd0);

      // Halt, ignore ops, resume drops its op
      step(OP_JMP, 11'd30);
      step(OP_HALT, '0);
      chk("halt_pc", 32'(bus.o_pc), 32'd31);
      chk("halt_flag", 32'(bus.o_halted), 32'd1);
      step(OP_INC, '0);
      chk("halted_inc_pc", 32'(bus.o_pc), 32'd31);
      chk("halted_stays", 32'(bus.o_halted), 32'd1);
      step(OP_JMP, 11'd500, 1'b1, 1'b1);
      chk("resume_pc", 32'(bus.o_pc), 32'd31);
      chk("resume_flag", 32'(bus.o_halted), 32'd0);
      step(OP_INC, '0);
      chk("post_resume_inc", 32'(bus.o_pc), 32'd32);

      // Resume is not gated by i_en
      step(OP_HALT, '0);
      chk("halt2_pc", 32'(bus.o_pc), 32'd33);
      step(OP_NOP, '0, 1'b0, 1'b1);
      chk("resume_en0", 32'(bus.o_halted), 32'd0);

      // Reset while halted
      step(OP_HALT, '0);
      do_reset();
      chk("rst_halt_pc", 32'(bus.o_pc), 32'd0);
      chk("rst_halt_flag", 32'(bus.o_halted), 32'd0);

`ifdef PC_CALL_STACK_EN
      // Nested calls and returns
      step(OP_JMP, 11'd5);
      step(OP_CALL, 11'd100);
      chk("call1_pc", 32'(bus.o_pc), 32'd100);
      step(OP_CALL, 11'd200);
      chk("call2_pc", 32'(bus.o_pc), 32'd200);
      chk("call2_lvl", 32'(bus.o_stack_level), 32'd2);
      step(OP_NOP, '0, 1'b0);
      chk("stall_lvl", 32'(bus.o_stack_level), 32'd2);
      step(OP_RET, '0);
      chk("ret1_pc", 32'(bus.o_pc), 32'd101);
      step(OP_RET, '0);
      chk("ret2_pc", 32'(bus.o_pc), 32'd6);
      chk("ret2_lvl", 32'(bus.o_stack_level), 32'd0);

      // Overflow on the 5th call
      for (int i = 0; i < 4; i++) step(OP_CALL, 11'(300 + i));
      chk("call4_pc", 32'(bus.o_pc), 32'd303);
      chk("call4_lvl", 32'(bus.o_stack_level), 32'd4);
      chk("call4_fault", 32'(bus.o_fault), 32'd0);
      step(OP_CALL, 11'd304);
      chk("ovf_fault", 32'(bus.o_fault), 32'd1);
      chk("ovf_pc", 32'(bus.o_pc), 32'd303);
      chk("ovf_lvl", 32'(bus.o_stack_level), 32'd4);
      step(OP_INC, '0, 1'b1, 1'b1);
      chk("fault_sticky_pc", 32'(bus.o_pc), 32'd303);
      do_reset();
      chk("ovf_rst_fault", 32'(bus.o_fault), 32'd0);
      chk("ovf_rst_lvl", 32'(bus.o_stack_level), 32'd0);

      // Underflow
      step(OP_JMP, 11'd20);
      step(OP_RET, '0);
      chk("unf_fault", 32'(bus.o_fault), 32'd1);
      chk("unf_pc", 32'(bus.o_pc), 32'd20);
      step(OP_JMP, 11'd99);
      chk("unf_ignore", 32'(bus.o_pc), 32'd20);
      do_reset();
      chk("unf_rst_fault", 32'(bus.o_fault), 32'd0);
`else
      // Without the stack: CALL jumps, RET holds, no fault
      step(OP_JMP, 11'd8);
      step(OP_CALL, 11'd50);
      chk("call_as_jmp_pc", 32'(bus.o_pc), 32'd50);
      chk("call_as_jmp_lvl", 32'(bus.o_stack_level), 32'd0);
      step(OP_RET, '0);
      chk("ret_as_nop_pc", 32'(bus.o_pc), 32'd50);
      chk("ret_as_nop_fault", 32'(bus.o_fault), 32'd0);
      step(OP_RET, '0);
      step(OP_INC, '0);
      chk("after_ret_inc", 32'(bus.o_pc), 32'd51);
      chk("after_ret_fault", 32'(bus.o_fault), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor fetch stage. It generates the instruction-memory address. Each cycle it performs one of the following: hold, increment, absolute jump, PC-relative branch, call or return. It also owns a small return-address stack and halt/fault status. It sits between the instruction decoder, which supplies the op and target, and the program memory address port.

## Interface

Parameters:
- PC_W, 11, program counter width in bits; address space is 2^PC_W.
- STACK_DEPTH, 4, number of return-address entries (>= 1).
- RESET_PC, 0, value loaded into o_pc on reset.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  advance enable. When low, all state holds (stall).
- i_op  in  3  sequencing operation, encodings in package.
- i_target  in  PC_W  jump/call address, or signed branch offset for BR.
- i_resume  in  1  leave HALTED, sampled only in HALTED.
- o_pc  out  PC_W  current fetch address, registered.
- o_halted  out  1  high while in HALTED.
- o_fault  out  1  high while in FAULT (stack overflow/underflow).
- o_stack_level  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.

## Operation

- States:
  - RUN: normal sequencing.
  - HALTED: o_pc frozen; i_resume=1 returns to RUN.
  - FAULT: o_pc frozen; exits only by i_rst.
- Ops are decoded only when state=RUN and i_en=1. Otherwise o_pc and the stack hold.
- Op encodings:
  - NOP=0: o_pc holds.
  - INC=1: o_pc <= o_pc+1.
  - JMP=2: o_pc <= i_target.
  - BR=3: o_pc <= o_pc + sign-extended i_target (two's complement, PC_W bits).
  - CALL=4:
    - Push o_pc+1, o_pc <= i_target.
    - If stack full: no push, o_pc holds, go to FAULT.
  - RET=5:
    - o_pc <= top entry, pop.
    - If stack empty: o_pc holds, go to FAULT.
  - HALT=6: o_pc <= o_pc+1, go to HALTED.
  - 7: reserved, treated as NOP.
- All PC arithmetic is modulo 2^PC_W. Overflow and underflow wrap silently, e.g. 2^PC_W-1 +1 -> 0.
- Stack is LIFO. Push and pop never occur in the same cycle, because one op is active per cycle.
- Reset values:
  - o_pc=RESET_PC, state=RUN, o_halted=0, o_fault=0, o_stack_level=0.
  - Stack contents are don't-care.
- Reset has priority over i_en, i_op and i_resume, in any state and mid-sequence.

## Timing

- Single-cycle latency. The op sampled at edge N is visible on o_pc after edge N.
- RET reads the top entry combinationally from the stack register array. The new o_pc appears after the same edge.
- o_halted and o_fault rise in the cycle after the HALT edge or the faulting edge.
- HALTED -> RUN takes one edge with i_resume=1. The op presented on that edge is ignored; decoding resumes on the next edge.
- i_en=0 in RUN freezes everything, including the stack level. i_en does not gate i_resume.

## Configuration

- PC_CALL_STACK_EN defined: full behaviour as above.
- PC_CALL_STACK_EN undefined:
  - No stack storage.
  - CALL behaves as JMP, RET behaves as NOP.
  - FAULT is unreachable; o_fault and o_stack_level are tied 0.

## Structure

- Package pc_seq_pkg holds:
  - the op encoding constants (OP_NOP … OP_HALT);
  - the state enum (ST_RUN, ST_HALTED, ST_FAULT).
- One sub-module, pc_return_stack (parameters PC_W, STACK_DEPTH):
  - inputs: push, pop, data;
  - outputs: top, level, full, empty.
- It is instantiated only under PC_CALL_STACK_EN.

## Test plan

- Reset sequencing: reset with RESET_PC=0 -> o_pc=0, o_halted=0, o_fault=0. Then 3 INC edges -> o_pc=3.
- Wrap and branch (PC_W=11):
  - o_pc=2047, INC -> o_pc=0.
  - o_pc=10, BR with i_target=11'h7FD (-3) -> o_pc=7.
- Nested calls and overflow (STACK_DEPTH=4):
  - CALL 100 from 5, then CALL 200 -> level=2.
  - RET -> o_pc=101, RET -> o_pc=6, level=0.
  - 5 consecutive CALLs -> 5th sets o_fault=1 and o_pc holds; reset clears it.
- Underflow: RET with empty stack at o_pc=20 -> o_fault=1, o_pc=20. Later ops are ignored until reset.
- Halt and stall:
  - HALT at o_pc=30 -> o_pc=31, o_halted=1. INC is ignored while halted.
  - i_resume=1 -> o_halted=0 next cycle.
  - i_en=0 with INC for 4 cycles -> o_pc unchanged.
- Macro off: CALL 50 from 8 -> o_pc=50, o_stack_level=0. RET -> o_pc=50, o_fault=0.
